parking_gate_ctrl: RTL and testbench

- Upstream front-end for the Parking counter block.
- Converts raw, asynchronous loop-sensor and badge levels at the entry and exit lanes into clean single-cycle event pulses: ci, uci, ce, uce.
- Gates entry requests against the vacancy flags ivs and uivs that Parking feeds back.
- Drives the barrier-open outputs for each lane.

---
 rtl/parking_gate_ctrl.sv | 158 +++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Entry/exit lane front-end for the Parking counter: synchronizes and debounces raw
// loop/badge levels, gates entries on vacancy, and times the barrier-open windows.
module parking_gate_ctrl #(
   parameter int unsigned SYNC_STAGES         = 2,
   parameter int unsigned DEBOUNCE_CYCLES     = 4,
   parameter int unsigned BARRIER_OPEN_CYCLES = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic entry_sensor,
   input  logic entry_badge,
   input  logic exit_sensor,
   input  logic exit_badge,
   input  logic ivs,
   input  logic uivs,
   output logic ci,
   output logic uci,
   output logic ce,
   output logic uce,
   output logic entry_gate_open,
   output logic exit_gate_open,
   output logic entry_reject
);

   typedef enum logic [2:0] {StIdle, StDebounce, StDecide, StOpen, StWaitClear} state_e;

   localparam logic [3:0] DebTarget  = 4'(DEBOUNCE_CYCLES);
   localparam logic [7:0] GateTarget = 8'(BARRIER_OPEN_CYCLES);

   logic [3:0]             raw;
   logic [SYNC_STAGES-1:0] sync_q [4];
   logic [1:0]             sens;
   logic [1:0]             badge;
   logic [1:0]             vac;

   // Lane 0 is entry, lane 1 is exit.
   state_e     state_q [2];
   state_e     state_d [2];
   logic [3:0] deb_q [2];
   logic [3:0] deb_d [2];
   logic [7:0] gate_cnt_q [2];
   logic [7:0] gate_cnt_d [2];
   logic [1:0] open_q, open_d;
   logic [1:0] gen_q, gen_d;
   logic [1:0] uni_q, uni_d;
   logic       rej_q, rej_d;

   assign raw   = {exit_badge, exit_sensor, entry_badge, entry_sensor};
   assign sens  = {sync_q[2][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};
   assign badge = {sync_q[3][SYNC_STAGES-1], sync_q[1][SYNC_STAGES-1]};
   // The exit lane never needs a free space.
   assign vac   = {1'b1, badge[0] ? uivs : ivs};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            sync_q[i][0] <= raw[i];
            for (int s = 1; s < SYNC_STAGES; s++) begin
               sync_q[i][s] <= sync_q[i][s-1];
            end
         end
      end
   end

   // The decision is registered on the DEBOUNCE->DECIDE edge, so the pulse and the
   // first open cycle coincide with the single DECIDE cycle.
   always_comb begin
      rej_d = 1'b0;
      for (int l = 0; l < 2; l++) begin
         state_d[l]    = state_q[l];
         deb_d[l]      = deb_q[l];
         gate_cnt_d[l] = gate_cnt_q[l];
         open_d[l]     = open_q[l];
         gen_d[l]      = 1'b0;
         uni_d[l]      = 1'b0;
         unique case (state_q[l])
            StIdle: begin
               if (sens[l]) begin
                  state_d[l] = StDebounce;
                  deb_d[l]   = 4'd1;
               end
            end
            StDebounce: begin
               if (!sens[l]) begin
                  state_d[l] = StIdle;
                  deb_d[l]   = '0;
               end else if (deb_q[l] == DebTarget) begin
                  state_d[l] = StDecide;
                  deb_d[l]   = '0;
                  if (vac[l]) begin
                     gen_d[l]      = !badge[l];
                     uni_d[l]      = badge[l];
                     open_d[l]     = 1'b1;
                     gate_cnt_d[l] = 8'd1;
                  end else begin
                     rej_d = 1'b1;
                  end
               end else if (deb_q[l] != 4'hf) begin
                  deb_d[l] = deb_q[l] + 4'd1;
               end
            end
            StDecide, StOpen: begin
               if (!open_q[l] || gate_cnt_q[l] == GateTarget) begin
                  state_d[l]    = StWaitClear;
                  open_d[l]     = 1'b0;
                  gate_cnt_d[l] = '0;
               end else begin
                  state_d[l]    = StOpen;
                  gate_cnt_d[l] = gate_cnt_q[l] + 8'd1;
               end
            end
            StWaitClear: begin
               if (!sens[l]) begin
                  state_d[l] = StIdle;
               end
            end
            default: state_d[l] = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int l = 0; l < 2; l++) begin
            state_q[l]    <= StIdle;
            deb_q[l]      <= '0;
            gate_cnt_q[l] <= '0;
         end
         open_q <= '0;
         gen_q  <= '0;
         uni_q  <= '0;
         rej_q  <= 1'b0;
      end else begin
         for (int l = 0; l < 2; l++) begin
            state_q[l]    <= state_d[l];
            deb_q[l]      <= deb_d[l];
            gate_cnt_q[l] <= gate_cnt_d[l];
         end
         open_q <= open_d;
         gen_q  <= gen_d;
         uni_q  <= uni_d;
         rej_q  <= rej_d;
      end
   end

   assign ci              = gen_q[0];
   assign uci             = uni_q[0];
   assign ce              = gen_q[1];
   assign uce             = uni_q[1];
   assign entry_gate_open = open_q[0];
   assign exit_gate_open  = open_q[1];
   assign entry_reject    = rej_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: an edge-indexed episode model checked every
// cycle, plus literal latency/width/count expectations per scenario.
module tb_parking_gate_ctrl;

   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int BOC  = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic entry_sensor = 1'b1, entry_badge = 1'b1, exit_sensor = 1'b1, exit_badge = 1'b1;
   logic ivs = 1'b1, uivs = 1'b1;
   logic ci, uci, ce, uce, entry_gate_open, exit_gate_open, entry_reject;

   parking_gate_ctrl #(
      .SYNC_STAGES        (SYNC),
      .DEBOUNCE_CYCLES    (DEB),
      .BARRIER_OPEN_CYCLES(BOC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .entry_sensor   (entry_sensor),
      .entry_badge    (entry_badge),
      .exit_sensor    (exit_sensor),
      .exit_badge     (exit_badge),
      .ivs            (ivs),
      .uivs           (uivs),
      .ci             (ci),
      .uci            (uci),
      .ce             (ce),
      .uce            (uce),
      .entry_gate_open(entry_gate_open),
      .exit_gate_open (exit_gate_open),
      .entry_reject   (entry_reject)
   );

   initial forever #5 clk = ~clk;

   // Bit order: 0 ci, 1 uci, 2 ce, 3 uce, 4 entry gate, 5 exit gate, 6 reject.
   logic [6:0] dut_vec;
   assign dut_vec = {entry_reject, exit_gate_open, entry_gate_open, uce, ce, uci, ci};

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: count consecutive raw-high samples per lane; the (DEB+1)th triggers an
   // event whose outputs appear SYNC edges later. The lane then ignores the sensor
   // until a raw-low sample that the lane can see after the barrier has closed.
   int         n;
   int         run [2];
   bit         locked [2];
   bit         pending [2];
   int         pend_edge [2];
   bit         pbadge [2];
   int         gate_until [2];
   int         release_from [2];
   logic [6:0] exp_vec;

   task automatic model_reset();
      n = 0;
      exp_vec = '0;
      for (int l = 0; l < 2; l++) begin
         run[l] = 0; locked[l] = 0; pending[l] = 0; pend_edge[l] = 0; pbadge[l] = 0;
         gate_until[l] = 0; release_from[l] = 0;
      end
   endtask

   task automatic model_step();
      logic [1:0] rs, rb;
      bit accept;
      rs = {exit_sensor, entry_sensor};
      rb = {exit_badge, entry_badge};
      n++;
      exp_vec = '0;
      for (int l = 0; l < 2; l++) begin
         if (pending[l] && n == pend_edge[l]) begin
            pending[l] = 0;
            accept = (l == 1) || (pbadge[l] ? uivs : ivs);
            if (accept) begin
               exp_vec[l*2 + (pbadge[l] ? 1 : 0)] = 1'b1;
               gate_until[l]   = n + BOC;
               release_from[l] = n - SYNC + BOC + 1;
            end else begin
               exp_vec[6]      = 1'b1;
               release_from[l] = n - SYNC + 2;
            end
         end
         exp_vec[4+l] = (n < gate_until[l]);
         if (locked[l]) begin
            if (!rs[l] && n >= release_from[l]) locked[l] = 0;
         end else begin
            run[l] = rs[l] ? run[l] + 1 : 0;
            if (run[l] == DEB + 1) begin
               locked[l]       = 1;
               pending[l]      = 1;
               pend_edge[l]    = n + SYNC;
               pbadge[l]       = rb[l];
               release_from[l] = 32'h7fff_ffff;
               run[l]          = 0;
            end
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   always @(negedge clk) begin
      #2;
      check("cycle_outputs", int'(dut_vec), int'(exp_vec));
   end

   int first [7];
   int cnt [7];

   task automatic observe(input int edges, input bit clr);
      if (clr) begin
         for (int j = 0; j < 7; j++) begin
            first[j] = 0;
            cnt[j]   = 0;
         end
      end
      for (int k = 1; k <= edges; k++) begin
         @(posedge clk);
         #1;
         for (int j = 0; j < 7; j++) begin
            if (dut_vec[j]) begin
               cnt[j]++;
               if (first[j] == 0) first[j] = k;
            end
         end
      end
   endtask

   task automatic drive(input logic es, input logic eb, input logic xs, input logic xb,
                        input logic iv, input logic uv);
      @(negedge clk);
      entry_sensor = es; entry_badge = eb; exit_sensor = xs; exit_badge = xb;
      ivs = iv; uivs = uv;
   endtask

   function automatic int total();
      int t = 0;
      for (int j = 0; j < 7; j++) t += cnt[j];
      return t;
   endfunction

   initial begin
      // Reset held with every input high.
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs", int'(dut_vec), 0);
      entry_sensor = 0; entry_badge = 0; exit_sensor = 0; exit_badge = 0;
      ivs = 0; uivs = 0;
      rst_n = 1'b1;
      observe(20, 1);
      check("idle_activity", total(), 0);

      // General entry.
      drive(1, 0, 0, 0, 1, 1);
      observe(30, 1);
      check("ci_latency", first[0], 7);
      check("ci_count", cnt[0], 1);
      check("entry_gate_cycles", cnt[4], BOC);
      check("entry_gate_start", first[4], 7);
      check("gen_entry_uci", cnt[1], 0);
      drive(0, 0, 0, 0, 1, 1);
      observe(10, 1);

      // University entry with full lot, then with space.
      drive(1, 1, 0, 0, 1, 0);
      observe(20, 1);
      check("reject_latency", first[6], 7);
      check("reject_count", cnt[6], 1);
      check("full_uci_ci", cnt[0] + cnt[1], 0);
      check("full_gate", cnt[4], 0);
      drive(0, 1, 0, 0, 1, 0);
      observe(10, 1);
      drive(1, 1, 0, 0, 1, 1);
      observe(20, 1);
      check("uci_latency", first[1], 7);
      check("uci_count", cnt[1], 1);
      drive(0, 0, 0, 0, 1, 1);
      observe(10, 1);

      // Three-cycle glitch, then a full assertion.
      drive(1, 0, 0, 0, 1, 1);
      observe(3, 1);
      drive(0, 0, 0, 0, 1, 1);
      observe(15, 0);
      check("glitch_activity", total(), 0);
      drive(1, 0, 0, 0, 1, 1);
      observe(20, 1);
      check("post_glitch_ci", first[0], 7);
      drive(0, 0, 0, 0, 1, 1);
      observe(10, 1);

      // Both lanes on the same edge.
      drive(1, 0, 1, 1, 1, 1);
      observe(20, 1);
      check("sim_ci", first[0], 7);
      check("sim_uce", first[3], 7);
      check("sim_ce", cnt[2], 0);
      check("sim_entry_gate", cnt[4], BOC);
      check("sim_exit_gate", cnt[5], BOC);
      drive(0, 0, 0, 0, 1, 1);
      observe(10, 1);

      // Reset in the third open cycle with the sensor held high.
      drive(1, 0, 0, 0, 1, 1);
      observe(9, 1);
      check("open_before_reset", cnt[4], 3);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("gate_drop_on_reset", int'(entry_gate_open), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      observe(20, 1);
      check("post_reset_ci", first[0], 7);
      check("post_reset_ci_count", cnt[0], 1);
      drive(0, 0, 0, 0, 1, 1);
      observe(10, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
